bcd_updown_counter: RTL and testbench
=====================================

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 2, which sets the number of BCD decades (range 1..8).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have port en, input, 1 bit: count enable.
REQ-005 The block SHALL have port up, input, 1 bit: direction select; 1 counts up, 0 counts down.
REQ-006 The block SHALL have port load, input, 1 bit: synchronous parallel-load strobe.
REQ-007 The block SHALL have port din, input, 4*DIGITS bits: BCD load value; the least significant digit is in [3:0].
REQ-008 The block SHALL have port count, output, 4*DIGITS bits: the registered BCD count, in the same digit order as din.
REQ-009 The block SHALL have port tc, output, 1 bit: combinational terminal count.
REQ-010 The block SHALL have port wrap, output, 1 bit: registered one-cycle pulse flagging a wrap-around.
REQ-011 The block SHALL have port load_err, output, 1 bit: registered one-cycle pulse flagging a rejected load.

Function
REQ-012 The count SHALL always hold legal BCD (every digit 0..9) and span 0 to 10^DIGITS-1.
REQ-013 Per-edge priority SHALL be: load, then en, then hold.
REQ-014 When load=1 and every din digit is <=9, count SHALL take din on that edge (1-cycle latency), regardless of en and up.
REQ-015 When load=1 and any din digit is >9, count SHALL hold and load_err SHALL be 1 for the next cycle only.
REQ-016 When load=0, en=1 and up=1, the count SHALL increment by one decimal unit.
REQ-017 On increment, a digit at 9 SHALL go to 0 and carry into the next digit; otherwise it SHALL increment and stop the carry.
REQ-018 When load=0, en=1 and up=0, the count SHALL decrement by one decimal unit.
REQ-019 On decrement, a digit at 0 SHALL go to 9 and borrow from the next digit; otherwise it SHALL decrement and stop the borrow.
REQ-020 Up-count wrap: count all 9s with en=1, up=1 SHALL give all 0s next, and wrap SHALL be 1 for exactly that following cycle.
REQ-021 Down-count wrap: count all 0s with en=1, up=0 SHALL give all 9s next, and wrap SHALL be 1 for exactly that following cycle.
REQ-022 tc SHALL equal en & ~load & (up ? count==all 9s : count==all 0s), with no register stage.
REQ-023 Toggling up between cycles SHALL take effect on the very next enabled edge, with no dead cycle.
REQ-024 A load on the edge where a wrap would otherwise occur SHALL suppress wrap; load_err and wrap SHALL never both be 1.
REQ-025 When en=0 and load=0, count SHALL hold and wrap and load_err SHALL be 0.

Reset
REQ-026 While reset=0, count SHALL be all zeros and wrap and load_err SHALL be 0, immediately and without waiting for a clock edge.
REQ-027 Reset asserted mid-count SHALL abort any pending load or wrap pulse.
REQ-028 After reset deasserts, counting SHALL resume on the first rising edge with en=1.
REQ-029 Reset deassertion SHALL be treated as synchronous to clk by the integrator; no internal synchroniser is provided.

Structure
REQ-030 Shared package bcd_pkg SHALL hold BCD_W=4, BCD_MAX=4'd9 and a bcd_digit_t typedef; the block SHALL use no literal 9 or 4 for digit logic.
REQ-031 Per-decade next-value logic SHALL be a sub-module bcd_digit, replicated DIGITS times by generate and chained through a carry/borrow in and out.
REQ-032 bcd_digit SHALL take digit, up, cin and return next digit and cout, and SHALL contain no state.
REQ-033 Load validity checking and the wrap and load_err registers SHALL live in the top level.
REQ-034 Synthesis SHALL yield only 4*DIGITS+2 flops, with no latches.

Verification
REQ-035 The bench SHALL cover: DIGITS=2, reset then en=1, up=1 for 100 cycles -> count 00,01..99,00; wrap high only in the cycle after 99->00; tc high only while count=99.
REQ-036 The bench SHALL cover: load din=8'h05, then en=1, up=0 for 7 cycles -> count 05,04,03,02,01,00,99,98; wrap after 00->99.
REQ-037 The bench SHALL cover: load din=8'h3A -> count unchanged, load_err=1 for one cycle; then load 8'h39 -> count 39, load_err=0.
REQ-038 The bench SHALL cover: count=99, en=1, up=1, load=1, din=8'h42 -> count 42, wrap=0, tc=0.
REQ-039 The bench SHALL cover: counting at 57, reset pulsed low between edges -> count 00 immediately, before the next edge; count 01 on the first enabled edge after release.
REQ-040 The bench SHALL cover: DIGITS=4 from 0999 with up=1 -> 1000; then up=0 -> 0999 (full ripple carry and borrow).

Source files
------------

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD counter slice: digit width, the largest legal
// decimal digit, a digit type, and a digit-validity helper.
// No ports (package).
// -----------------------------------------------------------------------------
package bcd_pkg;

   localparam int BCD_W = 4;

   typedef logic [BCD_W-1:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX  = 4'd9;
   localparam bcd_digit_t BCD_ZERO = '0;
   localparam bcd_digit_t BCD_ONE  = bcd_digit_t'(1);

   // True when the nibble encodes a decimal digit (0..BCD_MAX).
   function automatic logic bcd_valid(input bcd_digit_t d);
      return (d <= BCD_MAX);
   endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// Stateless next-value logic for one BCD decade. When cin is set the digit
// steps one unit in the direction given by up; cout ripples the carry (up) or
// borrow (down) to the next decade.
// Ports:
//   digit      - current digit value
//   up         - 1: increment, 0: decrement
//   cin        - carry/borrow in; 0 means this decade holds
//   digit_next - digit value for the next edge
//   cout       - carry/borrow out to the next decade
// -----------------------------------------------------------------------------
module bcd_digit
   import bcd_pkg::*;
(
   input  bcd_digit_t digit,
   input  logic       up,
   input  logic       cin,
   output bcd_digit_t digit_next,
   output logic       cout
);

   // Step the digit and generate the ripple out of this decade.
   always_comb begin
      digit_next = digit;
      cout       = 1'b0;
      if (!cin) begin
         digit_next = digit;
         cout       = 1'b0;
      end else if (up) begin
         if (digit == BCD_MAX) begin
            digit_next = BCD_ZERO;
            cout       = 1'b1;
         end else begin
            digit_next = digit + BCD_ONE;
            cout       = 1'b0;
         end
      end else begin
         if (digit == BCD_ZERO) begin
            digit_next = BCD_MAX;
            cout       = 1'b1;
         end else begin
            digit_next = digit - BCD_ONE;
            cout       = 1'b0;
         end
      end
   end

endmodule : bcd_digit

// File: rtl/bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter
// Multi-decade BCD up/down counter with parallel load, load-value checking,
// terminal count and wrap / rejected-load pulses.
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous active-low reset
//   en       - count enable
//   up       - direction: 1 up, 0 down
//   load     - synchronous parallel load strobe (has priority over en)
//   din      - BCD load value, least significant digit in [3:0]
//   count    - registered BCD count
//   tc       - combinational terminal count
//   wrap     - registered one-cycle pulse after a wrap-around
//   load_err - registered one-cycle pulse after a rejected (non-BCD) load
// -----------------------------------------------------------------------------
module bcd_updown_counter
   import bcd_pkg::*;
#(
   parameter int DIGITS = 2
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic                    up,
   input  logic                    load,
   input  logic [BCD_W*DIGITS-1:0] din,
   output logic [BCD_W*DIGITS-1:0] count,
   output logic                    tc,
   output logic                    wrap,
   output logic                    load_err
);

   logic [BCD_W*DIGITS-1:0] count_r;
   logic [BCD_W*DIGITS-1:0] next_s;
   logic [DIGITS:0]         carry_s;
   logic                    din_ok_s;
   logic                    wrap_r;
   logic                    load_err_r;

   // The least significant decade always steps when counting.
   assign carry_s[0] = 1'b1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
         .digit      (count_r[g*BCD_W +: BCD_W]),
         .up         (up),
         .cin        (carry_s[g]),
         .digit_next (next_s[g*BCD_W +: BCD_W]),
         .cout       (carry_s[g+1])
      );
   end

   // Load value is accepted only if every nibble is a decimal digit.
   always_comb begin
      din_ok_s = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         din_ok_s = din_ok_s & bcd_valid(din[i*BCD_W +: BCD_W]);
      end
   end

   // The ripple out of the top decade is set exactly when the count sits at
   // all 9s (up) or all 0s (down), so it doubles as the terminal-count term.
   assign tc = en & ~load & carry_s[DIGITS];

   // Count register plus wrap / load_err pulse registers; load beats en.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_r    <= '0;
         wrap_r     <= 1'b0;
         load_err_r <= 1'b0;
      end else if (load) begin
         wrap_r <= 1'b0;
         if (din_ok_s) begin
            count_r    <= din;
            load_err_r <= 1'b0;
         end else begin
            count_r    <= count_r;
            load_err_r <= 1'b1;
         end
      end else if (en) begin
         count_r    <= next_s;
         wrap_r     <= carry_s[DIGITS];
         load_err_r <= 1'b0;
      end else begin
         count_r    <= count_r;
         wrap_r     <= 1'b0;
         load_err_r <= 1'b0;
      end
   end

   assign count    = count_r;
   assign wrap     = wrap_r;
   assign load_err = load_err_r;

endmodule : bcd_updown_counter

// File: tb/tb_bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_updown_counter
// Self-checking bench: a 2-decade and a 4-decade counter checked against an
// integer reference model (decimal arithmetic modulo 10^DIGITS).
// -----------------------------------------------------------------------------
module tb_bcd_updown_counter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;

   logic        en2 = 1'b0, up2 = 1'b0, load2 = 1'b0;
   logic [7:0]  din2 = 8'h00;
   logic [7:0]  count2;
   logic        tc2, wrap2, load_err2;

   logic        en4 = 1'b0, up4 = 1'b0, load4 = 1'b0;
   logic [15:0] din4 = 16'h0000;
   logic [15:0] count4;
   logic        tc4, wrap4, load_err4;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: plain integer value plus pending pulses.
   int   m2 = 0, m4 = 0;
   logic mw2 = 1'b0, me2 = 1'b0, mw4 = 1'b0, me4 = 1'b0;

   always #5 clk = ~clk;

   bcd_updown_counter #(.DIGITS(2)) u_dut2 (
      .clk(clk), .reset(reset), .en(en2), .up(up2), .load(load2), .din(din2),
      .count(count2), .tc(tc2), .wrap(wrap2), .load_err(load_err2)
   );

   bcd_updown_counter #(.DIGITS(4)) u_dut4 (
      .clk(clk), .reset(reset), .en(en4), .up(up4), .load(load4), .din(din4),
      .count(count4), .tc(tc4), .wrap(wrap4), .load_err(load_err4)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] to_bcd(input int v, input int nd);
      logic [31:0] r;
      int          p;
      r = '0;
      p = 1;
      for (int i = 0; i < nd; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic int from_bcd(input logic [31:0] d, input int nd);
      int v, p;
      v = 0;
      p = 1;
      for (int i = 0; i < nd; i++) begin
         v = v + int'(d[4*i +: 4]) * p;
         p = p * 10;
      end
      return v;
   endfunction

   function automatic logic is_bcd(input logic [31:0] d, input int nd);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < nd; i++) begin
         if (int'(d[4*i +: 4]) > 9) ok = 1'b0;
      end
      return ok;
   endfunction

   // One clock of stimulus on the selected counter (w = 2 or 4); checks tc
   // before the edge and count / wrap / load_err after it.
   task automatic cyc(input int w, input logic e, input logic u, input logic l,
                      input logic [31:0] d);
      int   mv, mx, nv;
      logic nw, ne, exp_tc;
      mv = (w == 2) ? m2 : m4;
      mx = (w == 2) ? 99 : 9999;
      if (w == 2) begin
         en2 = e; up2 = u; load2 = l; din2 = d[7:0];
      end else begin
         en4 = e; up4 = u; load4 = l; din4 = d[15:0];
      end
      #1;
      exp_tc = e & ~l & (u ? (mv == mx) : (mv == 0));
      check_eq($sformatf("tc%0d", w), {31'd0, (w == 2) ? tc2 : tc4}, {31'd0, exp_tc});
      nv = mv; nw = 1'b0; ne = 1'b0;
      if (l) begin
         if (is_bcd(d, w)) nv = from_bcd(d, w);
         else ne = 1'b1;
      end else if (e) begin
         if (u) begin
            nv = (mv == mx) ? 0 : mv + 1;
            nw = (mv == mx);
         end else begin
            nv = (mv == 0) ? mx : mv - 1;
            nw = (mv == 0);
         end
      end
      @(posedge clk);
      #1;
      if (w == 2) begin
         m2 = nv; mw2 = nw; me2 = ne;
         check_eq("count2", {24'd0, count2}, to_bcd(m2, 2));
         check_eq("wrap2", {31'd0, wrap2}, {31'd0, mw2});
         check_eq("load_err2", {31'd0, load_err2}, {31'd0, me2});
      end else begin
         m4 = nv; mw4 = nw; me4 = ne;
         check_eq("count4", {16'd0, count4}, to_bcd(m4, 4));
         check_eq("wrap4", {31'd0, wrap4}, {31'd0, mw4});
         check_eq("load_err4", {31'd0, load_err4}, {31'd0, me4});
      end
   endtask

   // Pulse reset low between edges and check the immediate clear.
   task automatic reset_pulse();
      #2;
      reset = 1'b0;
      #1;
      check_eq("rst_count2", {24'd0, count2}, 32'd0);
      check_eq("rst_wrap2", {31'd0, wrap2}, 32'd0);
      check_eq("rst_err2", {31'd0, load_err2}, 32'd0);
      check_eq("rst_count4", {16'd0, count4}, 32'd0);
      m2 = 0; m4 = 0; mw2 = 1'b0; me2 = 1'b0; mw4 = 1'b0; me4 = 1'b0;
      @(posedge clk);
      #1;
      check_eq("rst_hold2", {24'd0, count2}, 32'd0);
      reset = 1'b1;
   endtask

   initial begin
      // Reset state, with reset held from time zero.
      #12;
      check_eq("init_count2", {24'd0, count2}, 32'd0);
      check_eq("init_wrap2", {31'd0, wrap2}, 32'd0);
      check_eq("init_err2", {31'd0, load_err2}, 32'd0);
      check_eq("init_count4", {16'd0, count4}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Full up-count through 99 -> 00.
      for (int i = 0; i < 100; i++) cyc(2, 1'b1, 1'b1, 1'b0, 32'h0);
      check_eq("up100_count", {24'd0, count2}, 32'h00);
      check_eq("up100_wrap", {31'd0, wrap2}, 32'd1);

      // Load 05, count down through 00 -> 99 -> 98.
      cyc(2, 1'b0, 1'b0, 1'b1, 32'h05);
      for (int i = 0; i < 7; i++) cyc(2, 1'b1, 1'b0, 1'b0, 32'h0);
      check_eq("down_count", {24'd0, count2}, 32'h98);

      // Rejected load keeps the count; good load clears the error pulse.
      cyc(2, 1'b0, 1'b0, 1'b1, 32'h3A);
      check_eq("bad_load", {24'd0, count2}, 32'h98);
      cyc(2, 1'b0, 1'b0, 1'b1, 32'h39);
      check_eq("good_load", {24'd0, count2}, 32'h39);

      // Load on a would-be wrap edge suppresses wrap.
      cyc(2, 1'b0, 1'b0, 1'b1, 32'h99);
      cyc(2, 1'b1, 1'b1, 1'b1, 32'h42);
      check_eq("load_wrap_count", {24'd0, count2}, 32'h42);
      check_eq("load_wrap_wrap", {31'd0, wrap2}, 32'd0);

      // Reset aborts a pending wrap pulse.
      cyc(2, 1'b0, 1'b0, 1'b1, 32'h99);
      cyc(2, 1'b1, 1'b1, 1'b0, 32'h0);
      reset_pulse();

      // Counting at 57, reset mid-cycle, resume from 00 -> 01.
      cyc(2, 1'b0, 1'b0, 1'b1, 32'h56);
      cyc(2, 1'b1, 1'b1, 1'b0, 32'h0);
      check_eq("at57", {24'd0, count2}, 32'h57);
      reset_pulse();
      cyc(2, 1'b1, 1'b1, 1'b0, 32'h0);
      check_eq("after_rst", {24'd0, count2}, 32'h01);

      // Hold with en=0, load=0.
      cyc(2, 1'b0, 1'b1, 1'b0, 32'h0);

      // Randomized traffic, including invalid load values and direction flips.
      for (int i = 0; i < 300; i++) begin
         cyc(2, 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 7) == 0),
             32'($urandom_range(0, 255)));
      end
      cyc(2, 1'b0, 1'b0, 1'b0, 32'h0);

      // Four decades: ripple carry and borrow across all digits.
      cyc(4, 1'b0, 1'b0, 1'b1, 32'h0999);
      cyc(4, 1'b1, 1'b1, 1'b0, 32'h0);
      check_eq("ripple_up", {16'd0, count4}, 32'h1000);
      cyc(4, 1'b1, 1'b0, 1'b0, 32'h0);
      check_eq("ripple_down", {16'd0, count4}, 32'h0999);
      cyc(4, 1'b0, 1'b0, 1'b1, 32'h0000);
      cyc(4, 1'b1, 1'b0, 1'b0, 32'h0);
      check_eq("wrap4_down", {16'd0, count4}, 32'h9999);
      for (int i = 0; i < 200; i++) begin
         cyc(4, 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 9) == 0),
             32'($urandom_range(0, 65535)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_bcd_updown_counter
